// File: rtl/lcd_sequencer.sv
// Plays one fixed-length page of character-ROM entries into the LCD driver,
// one entry per data_ready/lcd_busy handshake, with loop, abort and watchdog.
module lcd_sequencer #(
   parameter int PAGE_BITS      = 2,
   parameter int INDEX_BITS     = 4,
   parameter int LAST_INDEX     = 15,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_BITS        = 20
) (
   input  logic                            clock,
   input  logic                            internal_reset_n,
   input  logic                            start,
   input  logic                            abort,
   input  logic [PAGE_BITS-1:0]            page_sel,
   input  logic                            loop_mode,
   input  logic                            lcd_busy,
   output logic [PAGE_BITS+INDEX_BITS-1:0] rom_address,
   output logic                            data_ready,
   output logic                            active,
   output logic                            done,
   output logic                            error
);

   // Handshake: data_ready is held with a stable rom_address until the LCD
   // raises lcd_busy; the edge that samples lcd_busy=1 is the acceptance and
   // drops data_ready. The next entry is offered only once lcd_busy is low.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_FREE = 3'd1,
      S_PRESENT   = 3'd2,
      S_DONE      = 3'd3,
      S_ERROR     = 3'd4
   } state_t;

   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(LAST_INDEX);
   localparam bit                    WD_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [TO_BITS-1:0]    WD_LAST  =
      TO_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t                state_q, state_d;
   logic [PAGE_BITS-1:0]  page_q, page_d;
   logic [INDEX_BITS-1:0] index_q, index_d;
   logic                  loop_q, loop_d;
   logic [TO_BITS-1:0]    wd_q, wd_d;

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      index_d = index_q;
      loop_d  = loop_q;
      wd_d    = wd_q;
      if (abort) begin
         state_d = S_IDLE;
         index_d = '0;
         wd_d    = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state_d = S_WAIT_FREE;
                  page_d  = page_sel;
                  loop_d  = loop_mode;
                  index_d = '0;
               end
            end
            S_WAIT_FREE: begin
               if (!lcd_busy) begin
                  state_d = S_PRESENT;
                  wd_d    = '0;
               end
            end
            S_PRESENT: begin
               // Acceptance takes precedence over a watchdog expiring in the same cycle.
               if (lcd_busy) begin
                  wd_d = '0;
                  if (index_q < LAST_IDX) begin
                     index_d = index_q + 1'b1;
                     state_d = S_WAIT_FREE;
                  end else if (loop_q) begin
                     index_d = '0;
                     state_d = S_WAIT_FREE;
                  end else begin
                     state_d = S_DONE;
                  end
               end else if (WD_EN) begin
                  if (wd_q == WD_LAST) begin
                     state_d = S_ERROR;
                  end else begin
                     wd_d = wd_q + 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge internal_reset_n) begin
      if (!internal_reset_n) begin
         state_q    <= S_IDLE;
         page_q     <= '0;
         index_q    <= '0;
         loop_q     <= 1'b0;
         wd_q       <= '0;
         data_ready <= 1'b0;
         active     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         index_q    <= index_d;
         loop_q     <= loop_d;
         wd_q       <= wd_d;
         // Flags are decoded from the next state so they stay registered.
         data_ready <= (state_d == S_PRESENT);
         active     <= (state_d == S_WAIT_FREE) || (state_d == S_PRESENT);
         done       <= (state_d == S_DONE);
         error      <= (state_d == S_ERROR);
      end
   end

   assign rom_address = {page_q, index_q};

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer: one-shot and looping playback, watchdog,
// abort, asynchronous reset and a stuck-busy LCD.
module tb_lcd_sequencer;

   logic       clock;
   logic       internal_reset_n;
   logic       start;
   logic       abort;
   logic [1:0] page_sel;
   logic       loop_mode;
   logic       lcd_busy;
   logic [5:0] rom_address;
   logic       data_ready;
   logic       active;
   logic       done;
   logic       error;

   int         n_vec;
   int         n_err;
   int         n_pres;
   int         busy_left;
   int         free_left;
   int         cyc;
   logic       chk_drop;
   logic       dr_prev;
   logic       done_seen;
   logic       injected;
   logic [5:0] exp_a;
   logic [5:0] exp_q[$];

   lcd_sequencer #(
      .PAGE_BITS      (2),
      .INDEX_BITS     (4),
      .LAST_INDEX     (15),
      .TIMEOUT_CYCLES (8),
      .TO_BITS        (4)
   ) dut (
      .clock            (clock),
      .internal_reset_n (internal_reset_n),
      .start            (start),
      .abort            (abort),
      .page_sel         (page_sel),
      .loop_mode        (loop_mode),
      .lcd_busy         (lcd_busy),
      .rom_address      (rom_address),
      .data_ready       (data_ready),
      .active           (active),
      .done             (done),
      .error            (error)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic model_reset();
      busy_left = 0;
      free_left = 0;
      chk_drop  = 1'b0;
      dr_prev   = 1'b0;
      n_pres    = 0;
   endtask

   // LCD model: 3 cycles busy per accept, then 2 cycles free. Each rising
   // data_ready is scored against the expected address queue.
   task automatic lcd_cycle();
      @(negedge clock);
      if (chk_drop) begin
         n_vec++;
         if (data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL drop_after_busy: data_ready=%b required 0", data_ready);
         end
         chk_drop = 1'b0;
      end
      if (data_ready && !dr_prev) begin
         n_vec++;
         n_pres++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL present_seq: rom_address=%h presented, none expected", rom_address);
         end else begin
            exp_a = exp_q.pop_front();
            if (rom_address !== exp_a) begin
               n_err++;
               $display("FAIL present_seq: rom_address=%h required %h", rom_address, exp_a);
            end
         end
      end
      dr_prev = data_ready;
      if (busy_left > 0) begin
         lcd_busy = 1'b1;
         busy_left--;
         if (busy_left == 0) free_left = 2;
      end else if (free_left > 0) begin
         lcd_busy = 1'b0;
         free_left--;
      end else if (data_ready) begin
         lcd_busy  = 1'b1;
         busy_left = 2;
         chk_drop  = 1'b1;
      end else begin
         lcd_busy = 1'b0;
      end
   endtask

   task automatic test_reset();
      internal_reset_n = 1'b0;
      start = 1'b0; abort = 1'b0; page_sel = 2'd0; loop_mode = 1'b0; lcd_busy = 1'b0;
      repeat (3) @(negedge clock);
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_flags: flags=%b required 0000", {data_ready, active, done, error});
      end
      n_vec++;
      if (rom_address !== 6'h00) begin
         n_err++;
         $display("FAIL reset_addr: rom_address=%h required 00", rom_address);
      end
      internal_reset_n = 1'b1;
      repeat (2) @(negedge clock);
      n_vec++;
      if ({data_ready, active, rom_address} !== 8'h00) begin
         n_err++;
         $display("FAIL idle_no_progress: dr/act/addr=%h required 00", {data_ready, active, rom_address});
      end
   endtask

   task automatic test_one_shot();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(6'h20 + 6'(i));
      model_reset();
      lcd_busy = 1'b0;
      @(negedge clock);
      start = 1'b1; page_sel = 2'd2; loop_mode = 1'b0;
      @(negedge clock);
      start = 1'b0; page_sel = 2'd3; loop_mode = 1'b1;
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0100 || rom_address !== 6'h20) begin
         n_err++;
         $display("FAIL start_latency: flags=%b addr=%h required 0100 20",
                  {data_ready, active, done, error}, rom_address);
      end
      cyc = 0;
      while (!done && cyc < 400) begin
         lcd_cycle();
         cyc++;
      end
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0010 || rom_address !== 6'h2F) begin
         n_err++;
         $display("FAIL one_shot_done: flags=%b addr=%h required 0010 2f",
                  {data_ready, active, done, error}, rom_address);
      end
      n_vec++;
      if (n_pres != 16 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL one_shot_count: presented=%0d left=%0d required 16 0", n_pres, exp_q.size());
      end
      repeat (20) lcd_cycle();
      n_vec++;
      if (n_pres != 16 || done !== 1'b1 || rom_address !== 6'h2F) begin
         n_err++;
         $display("FAIL done_hold: presented=%0d done=%b addr=%h required 16 1 2f",
                  n_pres, done, rom_address);
      end
   endtask

   task automatic test_loop();
      exp_q.delete();
      for (int i = 0; i < 40; i++) exp_q.push_back(6'h10 + 6'(i % 16));
      model_reset();
      done_seen = 1'b0;
      @(negedge clock);
      start = 1'b1; page_sel = 2'd1; loop_mode = 1'b1; lcd_busy = 1'b0;
      @(negedge clock);
      start = 1'b0; page_sel = 2'd2; loop_mode = 1'b0;
      cyc = 0;
      while (n_pres < 40 && cyc < 600) begin
         lcd_cycle();
         done_seen = done_seen | done;
         cyc++;
      end
      n_vec++;
      if (n_pres != 40 || done_seen !== 1'b0) begin
         n_err++;
         $display("FAIL loop_run: presented=%0d done_seen=%b required 40 0", n_pres, done_seen);
      end
      abort = 1'b1;
      chk_drop = 1'b0;
      @(negedge clock);
      abort = 1'b0; lcd_busy = 1'b0;
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0000 || rom_address !== 6'h10) begin
         n_err++;
         $display("FAIL loop_abort: flags=%b addr=%h required 0000 10",
                  {data_ready, active, done, error}, rom_address);
      end
   endtask

   task automatic test_abort();
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(6'h20 + 6'(i));
      model_reset();
      injected = 1'b0;
      @(negedge clock);
      start = 1'b1; page_sel = 2'd2; loop_mode = 1'b0; lcd_busy = 1'b0;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (n_pres < 6 && cyc < 300) begin
         lcd_cycle();
         start = 1'b0;
         if (n_pres == 3 && !injected) begin
            start = 1'b1; page_sel = 2'd0; loop_mode = 1'b1;
            injected = 1'b1;
         end
         cyc++;
      end
      n_vec++;
      if (data_ready !== 1'b1 || rom_address !== 6'h25) begin
         n_err++;
         $display("FAIL pre_abort: dr=%b addr=%h required 1 25", data_ready, rom_address);
      end
      lcd_busy = 1'b0; busy_left = 0; chk_drop = 1'b0;
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0000 || rom_address !== 6'h20) begin
         n_err++;
         $display("FAIL abort_present: flags=%b addr=%h required 0000 20",
                  {data_ready, active, done, error}, rom_address);
      end
      repeat (3) @(negedge clock);
      n_vec++;
      if ({data_ready, active} !== 2'b00 || rom_address !== 6'h20) begin
         n_err++;
         $display("FAIL abort_idle_hold: dr/act=%b addr=%h required 00 20", {data_ready, active}, rom_address);
      end
   endtask

   task automatic test_watchdog();
      lcd_busy = 1'b0;
      @(negedge clock);
      start = 1'b1; page_sel = 2'd3; loop_mode = 1'b0;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!data_ready && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      n_vec++;
      if (data_ready !== 1'b1 || rom_address !== 6'h30) begin
         n_err++;
         $display("FAIL wd_present: dr=%b addr=%h required 1 30", data_ready, rom_address);
      end
      repeat (7) @(negedge clock);
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b1100) begin
         n_err++;
         $display("FAIL wd_before_expiry: flags=%b required 1100", {data_ready, active, done, error});
      end
      @(negedge clock);
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0001 || rom_address !== 6'h30) begin
         n_err++;
         $display("FAIL wd_expiry: flags=%b addr=%h required 0001 30",
                  {data_ready, active, done, error}, rom_address);
      end
   endtask

   task automatic test_watchdog_race();
      @(negedge clock);
      start = 1'b1; page_sel = 2'd1; loop_mode = 1'b0; lcd_busy = 1'b0;
      @(negedge clock);
      start = 1'b0;
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0100 || rom_address !== 6'h10) begin
         n_err++;
         $display("FAIL restart_from_error: flags=%b addr=%h required 0100 10",
                  {data_ready, active, done, error}, rom_address);
      end
      cyc = 0;
      while (!data_ready && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      repeat (7) @(negedge clock);
      lcd_busy = 1'b1;
      @(negedge clock);
      lcd_busy = 1'b0;
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0100 || rom_address !== 6'h11) begin
         n_err++;
         $display("FAIL wd_accept_wins: flags=%b addr=%h required 0100 11",
                  {data_ready, active, done, error}, rom_address);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      lcd_busy = 1'b0;
      @(negedge clock);
      start = 1'b1; page_sel = 2'd3; loop_mode = 1'b0;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!data_ready && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      #2 internal_reset_n = 1'b0;
      #1;
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0000 || rom_address !== 6'h00) begin
         n_err++;
         $display("FAIL async_reset: flags=%b addr=%h required 0000 00",
                  {data_ready, active, done, error}, rom_address);
      end
      @(negedge clock);
      internal_reset_n = 1'b1;
      repeat (4) @(negedge clock);
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0000 || rom_address !== 6'h00) begin
         n_err++;
         $display("FAIL post_reset_idle: flags=%b addr=%h required 0000 00",
                  {data_ready, active, done, error}, rom_address);
      end
   endtask

   task automatic test_stuck_busy();
      lcd_busy = 1'b1;
      @(negedge clock);
      start = 1'b1; page_sel = 2'd1; loop_mode = 1'b0;
      @(negedge clock);
      start = 1'b0;
      repeat (30) @(negedge clock);
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b0100 || rom_address !== 6'h10) begin
         n_err++;
         $display("FAIL stuck_busy_hold: flags=%b addr=%h required 0100 10",
                  {data_ready, active, done, error}, rom_address);
      end
      lcd_busy = 1'b0;
      @(negedge clock);
      n_vec++;
      if ({data_ready, active, done, error} !== 4'b1100 || rom_address !== 6'h10) begin
         n_err++;
         $display("FAIL busy_release: flags=%b addr=%h required 1100 10",
                  {data_ready, active, done, error}, rom_address);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      test_reset();
      test_one_shot();
      test_loop();
      test_abort();
      test_watchdog();
      test_watchdog_race();
      test_reset_mid();
      test_stuck_busy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
